// File: rtl/draw_menu_buttons.sv
// Button-column overlay for menu screens: draws N_BTN stacked rectangles on the
// pixel stream, outlines the selected one with a blinking border, and handles
// up/down/confirm keyboard navigation. Pixel path latency is two cycles.
module draw_menu_buttons #(
    parameter int          N_BTN        = 3,
    parameter int          BTN_X        = 400,
    parameter int          BTN_Y0       = 300,
    parameter int          BTN_W        = 224,
    parameter int          BTN_H        = 48,
    parameter int          BTN_PITCH    = 64,
    parameter int          BORDER       = 3,
    parameter logic [11:0] RECT_COLOR   = 12'h0F0,
    parameter logic [11:0] SEL_COLOR    = 12'hFF0,
    parameter int          BLINK_FRAMES = 30,
    parameter int          DEFAULT_SEL  = 0,
    localparam int         SW           = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          en_i,
    input  logic          nav_up_i,
    input  logic          nav_down_i,
    input  logic          nav_confirm_i,
    input  logic [10:0]   hcount_i,
    input  logic [10:0]   vcount_i,
    input  logic          hsync_i,
    input  logic          vsync_i,
    input  logic          hblnk_i,
    input  logic          vblnk_i,
    input  logic [11:0]   rgb_i,
    output logic [10:0]   hcount_o,
    output logic [10:0]   vcount_o,
    output logic          hsync_o,
    output logic          vsync_o,
    output logic          hblnk_o,
    output logic          vblnk_o,
    output logic [11:0]   rgb_o,
    output logic [SW-1:0] sel_o,
    output logic          choice_valid_o,
    output logic [SW-1:0] choice_idx_o
);

    localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    // Per-button geometry decode on the raw input coordinates (stage 1 inputs)
    logic [N_BTN-1:0] hit, bord;

    for (genvar k = 0; k < N_BTN; k++) begin : g_btn
        localparam logic [10:0] X0  = 11'(BTN_X);
        localparam logic [10:0] X1  = 11'(BTN_X + BTN_W);
        localparam logic [10:0] Y0  = 11'(BTN_Y0 + k * BTN_PITCH);
        localparam logic [10:0] Y1  = 11'(BTN_Y0 + k * BTN_PITCH + BTN_H);
        localparam logic [10:0] XI0 = 11'(BTN_X + BORDER);
        localparam logic [10:0] XI1 = 11'(BTN_X + BTN_W - BORDER);
        localparam logic [10:0] YI0 = 11'(BTN_Y0 + k * BTN_PITCH + BORDER);
        localparam logic [10:0] YI1 = 11'(BTN_Y0 + k * BTN_PITCH + BTN_H - BORDER);

        assign hit[k]  = (hcount_i >= X0) && (hcount_i < X1) &&
                         (vcount_i >= Y0) && (vcount_i < Y1);
        assign bord[k] = hit[k] && ((hcount_i < XI0) || (hcount_i >= XI1) ||
                                    (vcount_i < YI0) || (vcount_i >= YI1));
    end

    // Stage 1 registers
    logic [10:0]      hcount_s1_q, vcount_s1_q;
    logic             hsync_s1_q, vsync_s1_q, hblnk_s1_q, vblnk_s1_q;
    logic [11:0]      rgb_s1_q;
    logic             hit_s1_q;
    logic [N_BTN-1:0] bord_s1_q;
    logic             en_q;

    // Navigation / blink state
    logic [SW-1:0] sel_q, sel_d, disp_q, disp_d, cidx_q, cidx_d;
    logic          cv_q, cv_d;
    logic [CW-1:0] ctr_q, ctr_d;
    logic          blink_q, blink_d;
    logic          frame, en_rise;
    logic [11:0]   rgb_d;

    // en_q doubles as the previous-cycle en for edge detection and as the
    // stage-1 copy of en used by the colour mux.
    assign frame   = vblnk_i & ~vblnk_s1_q;
    assign en_rise = en_i & ~en_q;

    // Stage 1: capture timing, colour and geometry flags
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hcount_s1_q <= '0;
            vcount_s1_q <= '0;
            hsync_s1_q  <= 1'b0;
            vsync_s1_q  <= 1'b0;
            hblnk_s1_q  <= 1'b0;
            vblnk_s1_q  <= 1'b0;
            rgb_s1_q    <= '0;
            hit_s1_q    <= 1'b0;
            bord_s1_q   <= '0;
            en_q        <= 1'b0;
        end else begin
            hcount_s1_q <= hcount_i;
            vcount_s1_q <= vcount_i;
            hsync_s1_q  <= hsync_i;
            vsync_s1_q  <= vsync_i;
            hblnk_s1_q  <= hblnk_i;
            vblnk_s1_q  <= vblnk_i;
            rgb_s1_q    <= rgb_i;
            hit_s1_q    <= |hit;
            bord_s1_q   <= bord;
            en_q        <= en_i;
        end
    end

    // Selection, confirm, frame-latched display copy and blink sequencing
    always_comb begin
        sel_d   = sel_q;
        disp_d  = disp_q;
        cv_d    = 1'b0;
        cidx_d  = cidx_q;
        ctr_d   = ctr_q;
        blink_d = blink_q;
        if (en_rise) begin
            sel_d   = SW'(DEFAULT_SEL);
            disp_d  = SW'(DEFAULT_SEL);
            ctr_d   = '0;
            blink_d = 1'b1;
        end else begin
            if (en_i) begin
                if (nav_confirm_i) begin
                    cv_d   = 1'b1;
                    cidx_d = sel_q;
                end else if (nav_up_i && !nav_down_i) begin
                    sel_d = (sel_q == '0) ? SW'(N_BTN - 1) : sel_q - 1'b1;
                end else if (nav_down_i && !nav_up_i) begin
                    sel_d = (sel_q == SW'(N_BTN - 1)) ? '0 : sel_q + 1'b1;
                end
            end
            if (frame) disp_d = sel_q;
            // A fresh selection restarts the blink so the border shows at once
            if (sel_d != sel_q) begin
                ctr_d   = '0;
                blink_d = 1'b1;
            end else if (frame && (BLINK_FRAMES > 0)) begin
                if (ctr_q == CW'(BLINK_FRAMES - 1)) begin
                    ctr_d   = '0;
                    blink_d = ~blink_q;
                end else begin
                    ctr_d = ctr_q + 1'b1;
                end
            end
        end
    end

    // Navigation state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sel_q   <= SW'(DEFAULT_SEL);
            disp_q  <= SW'(DEFAULT_SEL);
            cv_q    <= 1'b0;
            cidx_q  <= '0;
            ctr_q   <= '0;
            blink_q <= 1'b1;
        end else begin
            sel_q   <= sel_d;
            disp_q  <= disp_d;
            cv_q    <= cv_d;
            cidx_q  <= cidx_d;
            ctr_q   <= ctr_d;
            blink_q <= blink_d;
        end
    end

    // Stage 2 colour priority: blanking, bypass, selection border, fill
    always_comb begin
        rgb_d = rgb_s1_q;
        if (hblnk_s1_q || vblnk_s1_q)           rgb_d = 12'h000;
        else if (!en_q)                         rgb_d = rgb_s1_q;
        else if (bord_s1_q[disp_q] && blink_q)  rgb_d = SEL_COLOR;
        else if (hit_s1_q)                      rgb_d = RECT_COLOR;
    end

    // Stage 2 output registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hcount_o <= '0;
            vcount_o <= '0;
            hsync_o  <= 1'b0;
            vsync_o  <= 1'b0;
            hblnk_o  <= 1'b0;
            vblnk_o  <= 1'b0;
            rgb_o    <= '0;
        end else begin
            hcount_o <= hcount_s1_q;
            vcount_o <= vcount_s1_q;
            hsync_o  <= hsync_s1_q;
            vsync_o  <= vsync_s1_q;
            hblnk_o  <= hblnk_s1_q;
            vblnk_o  <= vblnk_s1_q;
            rgb_o    <= rgb_d;
        end
    end

    assign sel_o          = sel_q;
    assign choice_valid_o = cv_q;
    assign choice_idx_o   = cidx_q;

endmodule
